ui_mode_ctrl: RTL and testbench

Parametrised button-driven mode/field controller for the board front end. It consumes three debounced active-low push-button levels and selects one of NUM_MODES display modes. Each mode holds FIELDS editable values, and a held increment button auto-repeats. Field edits are published as a write strobe for downstream RAM and game-state registers. It also packs the seven-segment digit values and LED mode indication, replacing the hand-written per-mode case logic in the top level.

---
 rtl/ui_mode_ctrl_if.sv | 27 ++
 rtl/ui_mode_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ui_mode_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ui_mode_ctrl_if.sv
// rtl/ui_mode_ctrl_if.sv - button inputs and mode/field/display outputs of ui_mode_ctrl
// master drives the buttons and observes the outputs; slave is the controller side.
interface ui_mode_ctrl_if #(
  parameter int FIELD_W = 6
);
  logic               BTN_MODE;
  logic               BTN_SEL;
  logic               BTN_INC;
  logic [3:0]         MODE;
  logic [3:0]         FIELD;
  logic [FIELD_W-1:0] VALUE;
  logic               WR_EN;
  logic [7:0]         WR_ADDR;
  logic [FIELD_W-1:0] WR_DATA;
  logic [19:0]        DISP_VALS;
  logic [3:0]         LEDS;

  modport master (
    output BTN_MODE, BTN_SEL, BTN_INC,
    input  MODE, FIELD, VALUE, WR_EN, WR_ADDR, WR_DATA, DISP_VALS, LEDS
  );

  modport slave (
    input  BTN_MODE, BTN_SEL, BTN_INC,
    output MODE, FIELD, VALUE, WR_EN, WR_ADDR, WR_DATA, DISP_VALS, LEDS
  );
endinterface

// File: rtl/ui_mode_ctrl.sv
// rtl/ui_mode_ctrl.sv - button-driven mode/field editor with auto-repeat increment
// Three active-low debounced buttons select a mode, a field, and increment the field value.
module ui_mode_ctrl #(
  parameter int NUM_MODES     = 5,
  parameter int FIELDS        = 4,
  parameter int FIELD_W       = 6,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input logic            CLK,
  input logic            RST_N,
  ui_mode_ctrl_if.slave  u_bus
);

  localparam int DEPTH   = NUM_MODES * FIELDS;
  localparam int IDX_W   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [3:0]       MODE_LAST  = 4'(NUM_MODES - 1);
  localparam logic [3:0]       FIELD_LAST = 4'(FIELDS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CYCLES - 1);

  // Button order in the 3-bit vectors: [2]=MODE, [1]=SEL, [0]=INC
  logic [2:0]         r_btn_prev;
  logic [2:0]         r_btn_arm;
  logic [3:0]         r_mode;
  logic [3:0]         r_field;
  logic [FIELD_W-1:0] r_mem [DEPTH];
  logic [FIELD_W-1:0] r_value;
  logic               r_wr_en;
  logic [7:0]         r_wr_addr;
  logic [FIELD_W-1:0] r_wr_data;
  logic [19:0]        r_disp;
  logic [3:0]         r_leds;
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;

  logic [2:0]         w_btn_lvl;
  logic [2:0]         w_btn_press;
  logic               w_mode_ev;
  logic               w_sel_ev;
  logic               w_inc_ev;
  logic               w_tick;
  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [3:0]         w_mode_nxt;
  logic [3:0]         w_field_nxt;
  logic [IDX_W-1:0]   w_idx_cur;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [FIELD_W-1:0] w_val_cur;
  logic [FIELD_W-1:0] w_val_inc;
  logic [FIELD_W-1:0] w_val_nxt;
  logic [7:0]         w_val8;
  logic [19:0]        w_disp_nxt;

  function automatic logic [IDX_W-1:0] f_idx(input logic [3:0] mode, input logic [3:0] field);
    int t;
    t = int'(mode) * FIELDS + int'(field);
    return IDX_W'(t);
  endfunction

  assign w_btn_lvl   = {u_bus.BTN_MODE, u_bus.BTN_SEL, u_bus.BTN_INC};
  // A press needs a released sample before it; the arm bit blocks buttons held through reset.
  assign w_btn_press = ~w_btn_lvl & r_btn_prev & r_btn_arm;

  assign w_mode_ev = w_btn_press[2];
  assign w_sel_ev  = w_btn_press[1] & ~w_mode_ev;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tick      = 1'b0;
    if (u_bus.BTN_INC || w_btn_press[2] || w_btn_press[1]) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
          if (w_btn_press[0]) begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_tick      = 1'b1;
            w_state_nxt = ST_REPEAT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (r_cnt == REP_LAST) begin
            w_tick    = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_inc_ev = ~w_btn_press[2] & ~w_btn_press[1] & (w_btn_press[0] | w_tick);

  always_comb begin
    w_mode_nxt  = r_mode;
    w_field_nxt = r_field;
    if (w_mode_ev) begin
      w_mode_nxt  = (r_mode == MODE_LAST) ? 4'd0 : r_mode + 4'd1;
      w_field_nxt = 4'd0;
    end else if (w_sel_ev) begin
      w_field_nxt = (r_field == FIELD_LAST) ? 4'd0 : r_field + 4'd1;
    end
  end

  assign w_idx_cur = f_idx(r_mode, r_field);
  assign w_idx_nxt = f_idx(w_mode_nxt, w_field_nxt);
  assign w_val_cur = r_mem[w_idx_cur];
  assign w_val_inc = w_val_cur + FIELD_W'(1);

  // Mode/field changes never coincide with an increment, so the next index is the written one.
  assign w_val_nxt  = w_inc_ev ? w_val_inc : r_mem[w_idx_nxt];
  assign w_val8     = 8'(w_val_nxt);
  assign w_disp_nxt = {1'b0, w_mode_nxt, 1'b0, w_val8[7:4], 1'b0, w_val8[3:0], 1'b0, w_field_nxt};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_btn_prev <= 3'b111;
      r_btn_arm  <= w_btn_lvl;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
    end else begin
      r_btn_prev <= w_btn_lvl;
      r_btn_arm  <= r_btn_arm | w_btn_lvl;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_inc_ev) begin
      r_mem[w_idx_cur] <= w_val_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_mode    <= '0;
      r_field   <= '0;
      r_value   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_disp    <= '0;
      r_leds    <= '0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_field <= w_field_nxt;
      r_value <= w_val_nxt;
      r_disp  <= w_disp_nxt;
      r_leds  <= w_mode_nxt;
      r_wr_en <= w_inc_ev;
      if (w_inc_ev) begin
        r_wr_addr <= {r_mode, r_field};
        r_wr_data <= w_val_inc;
      end
    end
  end

  assign u_bus.MODE      = r_mode;
  assign u_bus.FIELD     = r_field;
  assign u_bus.VALUE     = r_value;
  assign u_bus.WR_EN     = r_wr_en;
  assign u_bus.WR_ADDR   = r_wr_addr;
  assign u_bus.WR_DATA   = r_wr_data;
  assign u_bus.DISP_VALS = r_disp;
  assign u_bus.LEDS      = r_leds;

endmodule

// File: tb/tb_ui_mode_ctrl.sv
// tb/tb_ui_mode_ctrl.sv - self-checking bench for ui_mode_ctrl
// Directed steps; expected write strobes are queued and matched when WR_EN appears.
module tb_ui_mode_ctrl;

  localparam int NM = 5;
  localparam int NF = 4;
  localparam int FW = 6;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [5:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  wr_t  sb_q[$];

  logic [3:0] m_mode;
  logic [3:0] m_field;
  logic [5:0] m_mem [NM][NF];

  ui_mode_ctrl_if #(.FIELD_W(FW)) u_if ();

  ui_mode_ctrl #(
    .NUM_MODES    (NM),
    .FIELDS       (NF),
    .FIELD_W      (FW),
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(4)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .u_bus(u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (u_if.WR_EN === 1'b1) begin
      chk("wr_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
        chk("wr_addr", 32'(u_if.WR_ADDR), 32'(e.addr));
        chk("wr_data", 32'(u_if.WR_DATA), 32'(e.data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_mode  = '0;
    m_field = '0;
    for (int i = 0; i < NM; i++)
      for (int j = 0; j < NF; j++)
        m_mem[i][j] = '0;
  endtask

  task automatic check_state(input string tag);
    logic [7:0]  v8;
    logic [19:0] d;
    v8 = {2'b00, m_mem[m_mode][m_field]};
    d  = {1'b0, m_mode, 1'b0, v8[7:4], 1'b0, v8[3:0], 1'b0, m_field};
    chk({tag, ".mode"},  32'(u_if.MODE),      32'(m_mode));
    chk({tag, ".field"}, 32'(u_if.FIELD),     32'(m_field));
    chk({tag, ".value"}, 32'(u_if.VALUE),     32'(v8));
    chk({tag, ".leds"},  32'(u_if.LEDS),      32'(m_mode));
    chk({tag, ".disp"},  32'(u_if.DISP_VALS), 32'(d));
  endtask

  task automatic push_wr(input int at_cyc, input logic [5:0] data);
    wr_t e;
    e.cyc  = at_cyc;
    e.addr = {m_mode, m_field};
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic press_mode();
    u_if.BTN_MODE = 1'b0;
    tick(1);
    m_mode  = (m_mode == 4'(NM - 1)) ? 4'd0 : m_mode + 4'd1;
    m_field = 4'd0;
    check_state("mode_press");
    u_if.BTN_MODE = 1'b1;
    tick(1);
  endtask

  task automatic press_sel();
    u_if.BTN_SEL = 1'b0;
    tick(1);
    m_field = (m_field == 4'(NF - 1)) ? 4'd0 : m_field + 4'd1;
    check_state("sel_press");
    u_if.BTN_SEL = 1'b1;
    tick(1);
  endtask

  task automatic press_inc();
    push_wr(cyc + 1, m_mem[m_mode][m_field] + 6'd1);
    u_if.BTN_INC = 1'b0;
    tick(1);
    m_mem[m_mode][m_field] = m_mem[m_mode][m_field] + 6'd1;
    check_state("inc_press");
    u_if.BTN_INC = 1'b1;
    tick(1);
  endtask

  initial begin
    int         offs[6];
    int         k;
    logic [5:0] base;
    offs = '{0, 10, 14, 18, 22, 26};
    n_checks = 0;
    n_fail   = 0;
    u_if.BTN_MODE = 1'b1;
    u_if.BTN_SEL  = 1'b1;
    u_if.BTN_INC  = 1'b1;
    rst_n = 1'b0;
    model_reset();
    tick(3);
    check_state("reset");
    chk("reset.wr_en",   32'(u_if.WR_EN),   32'd0);
    chk("reset.wr_addr", 32'(u_if.WR_ADDR), 32'd0);
    chk("reset.wr_data", 32'(u_if.WR_DATA), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Mode wraps 1,2,3,4,0
    for (int i = 0; i < 5; i++) press_mode();
    chk("mode_wrapped", 32'(u_if.MODE), 32'd0);

    // Mode 2, field 1, three increments -> addr 0x21, data 1,2,3
    press_mode();
    press_mode();
    press_sel();
    for (int i = 0; i < 3; i++) press_inc();
    chk("m2f1.value", 32'(u_if.VALUE), 32'd3);
    for (int i = 0; i < 4; i++) press_sel();

    // All-ones wraps to zero
    press_mode();
    for (int i = 0; i < 63; i++) press_inc();
    chk("at63.value", 32'(u_if.VALUE), 32'd63);
    press_inc();
    chk("wrap.value",  32'(u_if.VALUE), 32'd0);
    chk("wrap.digit1", 32'(u_if.DISP_VALS[9:5]),   32'd0);
    chk("wrap.digit2", 32'(u_if.DISP_VALS[14:10]), 32'd0);

    // Auto-repeat: held 30 edges -> strobes at 0,10,14,18,22,26
    press_sel();
    base = m_mem[m_mode][m_field];
    k = cyc + 1;
    for (int j = 0; j < 6; j++) push_wr(k + offs[j], base + 6'(j + 1));
    u_if.BTN_INC = 1'b0;
    tick(30);
    u_if.BTN_INC = 1'b1;
    m_mem[m_mode][m_field] = base + 6'd6;
    tick(12);
    check_state("auto_done");
    chk("auto_drained", 32'(sb_q.size()), 32'd0);

    // MODE and INC in the same cycle: mode wins, no write
    u_if.BTN_MODE = 1'b0;
    u_if.BTN_INC  = 1'b0;
    tick(1);
    m_mode  = (m_mode == 4'(NM - 1)) ? 4'd0 : m_mode + 4'd1;
    m_field = 4'd0;
    check_state("mode_inc");
    chk("mode_inc.wr_en", 32'(u_if.WR_EN), 32'd0);
    u_if.BTN_MODE = 1'b1;
    u_if.BTN_INC  = 1'b1;
    tick(2);

    // SEL during HOLD cancels auto-repeat while INC stays held
    push_wr(cyc + 1, m_mem[m_mode][m_field] + 6'd1);
    u_if.BTN_INC = 1'b0;
    tick(1);
    m_mem[m_mode][m_field] = m_mem[m_mode][m_field] + 6'd1;
    check_state("hold_first");
    tick(4);
    u_if.BTN_SEL = 1'b0;
    tick(1);
    m_field = m_field + 4'd1;
    check_state("hold_sel");
    u_if.BTN_SEL = 1'b1;
    tick(25);
    check_state("hold_cancelled");
    u_if.BTN_INC = 1'b1;
    tick(1);
    press_inc();

    // Reset mid-hold with INC held through and after it
    push_wr(cyc + 1, m_mem[m_mode][m_field] + 6'd1);
    u_if.BTN_INC = 1'b0;
    tick(1);
    m_mem[m_mode][m_field] = m_mem[m_mode][m_field] + 6'd1;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    model_reset();
    check_state("rst_mid");
    chk("rst_mid.wr_en", 32'(u_if.WR_EN), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(15);
    check_state("post_rst_held");
    chk("post_rst.wr_en", 32'(u_if.WR_EN), 32'd0);
    u_if.BTN_INC = 1'b1;
    tick(1);
    press_inc();
    tick(2);
    chk("final_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
